// File: rtl/rv_multicycle_ctrl_pkg.sv
// rv_ctrl_pkg: shared definitions for the RV32I multi-cycle controller.
//   - Major opcode constants (also consumed by the immediate generator).
//   - state_t   : controller FSM states.
//   - op_class_t: instruction class produced by the opcode decoder.
//   - alu_op_t  : ALU operation select driven to the datapath.
//   - wb_sel_t  : register-file write-back source select.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_BRANCH = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_LOAD    = 3'd0,
    CL_STORE   = 3'd1,
    CL_ALU_I   = 3'd2,
    CL_ALU_R   = 3'd3,
    CL_LUI     = 3'd4,
    CL_BRANCH  = 3'd5,
    CL_ILLEGAL = 3'd6
  } op_class_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_IMM = 2'b10
  } wb_sel_t;

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// rv_multicycle_ctrl_if: the single shared memory port between the controller
// and the memory subsystem.
//   mem_req      : access request, held until mem_ready
//   mem_we       : write strobe (stores only)
//   mem_addr_sel : 0 = PC (fetch), 1 = ALU result (data access)
//   mem_ready    : memory completes the pending access this cycle
// master = controller side, slave = memory side.
interface rv_multicycle_ctrl_if;

  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );

endinterface

// File: rtl/rv_multicycle_ctrl_decode.sv
// rv_opcode_decode: purely combinational classification of the 7-bit major
// opcode into the instruction classes the controller sequences.
//   i_opcode : inst_code[6:0]
//   o_class  : load/store/alu_i/alu_r/lui/branch, or illegal for anything else
module rv_opcode_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output op_class_t  o_class
);

  always_comb begin
    o_class = CL_ILLEGAL;
    case (i_opcode)
      OP_LOAD:   o_class = CL_LOAD;
      OP_STORE:  o_class = CL_STORE;
      OP_ALU_I:  o_class = CL_ALU_I;
      OP_ALU_R:  o_class = CL_ALU_R;
      OP_LUI:    o_class = CL_LUI;
      OP_BRANCH: o_class = CL_BRANCH;
      default:   o_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle control FSM for the RV32I core. Sequences one
// instruction at a time through FETCH, DECODE, EXEC/BRANCH, MEM and WB.
// Ports:
//   clk, reset    : clock (rising edge) and asynchronous active-high reset
//   inst_code     : IR contents, valid from DECODE onward
//   alu_zero      : ALU zero flag for branch compare
//   mem           : shared memory port (master modport)
//   ir_write, pc_write, pc_sel, alu_src_b, alu_op, reg_write, wb_sel : datapath strobes
//   trap          : sticky illegal-instruction / memory-timeout indication
//   retired       : completed-instruction count, wraps
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           inst_code,
  input  logic                  alu_zero,
  rv_multicycle_ctrl_if.master  mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_sel,
  output logic                  alu_src_b,
  output logic [1:0]            alu_op,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic                  trap,
  output logic [CNT_W-1:0]      retired
);

  // Counter only needs to reach MEM_TIMEOUT-1; the trap fires on that cycle.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_retired;

  op_class_t   w_class;
  logic [2:0]  w_funct3;
  logic        w_br_legal;
  logic        w_br_taken;
  logic        w_timeout;
  logic        w_unused_bits;

  assign w_funct3      = inst_code[14:12];
  assign w_unused_bits = ^{inst_code[31:15], inst_code[11:7]};

  rv_opcode_decode u_decode (
    .i_opcode (inst_code[6:0]),
    .o_class  (w_class)
  );

  assign w_br_legal = (w_funct3 == F3_BEQ) || (w_funct3 == F3_BNE);
  assign w_br_taken = ((w_funct3 == F3_BEQ) &&  alu_zero) ||
                      ((w_funct3 == F3_BNE) && !alu_zero);

  // Fires on the last permitted wait cycle so that the next state is TRAP.
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem.mem_ready) begin
            r_state <= S_DECODE;
            r_wait  <= '0;
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_wait  <= '0;
          end else if (MEM_TIMEOUT != 0) begin
            r_wait  <= r_wait + 1'b1;
          end
        end
        S_DECODE: begin
          case (w_class)
            CL_ILLEGAL: r_state <= S_TRAP;
            CL_BRANCH:  r_state <= S_BRANCH;
            default:    r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          if (w_class == CL_LOAD || w_class == CL_STORE) r_state <= S_MEM;
          else                                           r_state <= S_WB;
        end
        S_BRANCH: begin
          if (w_br_legal) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + 1'b1;
          end else begin
            r_state   <= S_TRAP;
          end
        end
        S_MEM: begin
          if (mem.mem_ready) begin
            r_wait <= '0;
            if (w_class == CL_STORE) begin
              r_state   <= S_FETCH;
              r_retired <= r_retired + 1'b1;
            end else begin
              r_state   <= S_WB;
            end
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_wait  <= '0;
          end else if (MEM_TIMEOUT != 0) begin
            r_wait  <= r_wait + 1'b1;
          end
        end
        S_WB: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + 1'b1;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_TRAP;
      endcase
    end
  end

  // Strobes decode from state; gating with reset drops them the moment reset
  // asserts, even in the middle of a memory access.
  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_sel           = 1'b0;
    alu_src_b        = 1'b0;
    alu_op           = ALU_ADD;
    reg_write        = 1'b0;
    wb_sel           = WB_ALU;
    trap             = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          ir_write    = mem.mem_ready;
          pc_write    = mem.mem_ready;
        end
        S_EXEC: begin
          case (w_class)
            CL_ALU_R: begin alu_src_b = 1'b0; alu_op = ALU_FUNCT; end
            CL_ALU_I: begin alu_src_b = 1'b1; alu_op = ALU_FUNCT; end
            CL_LOAD,
            CL_STORE: begin alu_src_b = 1'b1; alu_op = ALU_ADD;   end
            default:  ;
          endcase
        end
        S_BRANCH: begin
          alu_op   = ALU_SUB;
          pc_write = w_br_taken;
          pc_sel   = 1'b1;
        end
        S_MEM: begin
          mem.mem_req      = 1'b1;
          mem.mem_addr_sel = 1'b1;
          mem.mem_we       = (w_class == CL_STORE);
        end
        S_WB: begin
          reg_write = 1'b1;
          if (w_class == CL_LOAD)     wb_sel = WB_MEM;
          else if (w_class == CL_LUI) wb_sel = WB_IMM;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign retired = r_retired;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
module tb_rv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_code;
  logic        alu_zero;

  logic        ir_write, pc_write, pc_sel, alu_src_b, reg_write, trap;
  logic [1:0]  alu_op, wb_sel;
  logic [31:0] retired;

  logic        d0_ir_write, d0_pc_write, d0_pc_sel, d0_alu_src_b, d0_reg_write, d0_trap;
  logic [1:0]  d0_alu_op, d0_wb_sel;
  logic [31:0] d0_retired;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_LW   = 32'h0000_2083;
  localparam logic [31:0] I_SW   = 32'h0010_2023;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_BNE  = 32'h0000_1063;
  localparam logic [31:0] I_BBAD = 32'h0000_2063;
  localparam logic [31:0] I_LUI  = 32'h1234_50b7;
  localparam logic [31:0] I_ADD  = 32'h0020_81b3;
  localparam logic [31:0] I_BAD  = 32'h0000_007f;

  always #5 clk = ~clk;

  rv_multicycle_ctrl_if mem_if ();
  rv_multicycle_ctrl_if mem_if0 ();

  rv_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .inst_code(inst_code), .alu_zero(alu_zero),
    .mem(mem_if), .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .wb_sel(wb_sel), .trap(trap), .retired(retired)
  );

  rv_multicycle_ctrl #(.MEM_TIMEOUT(0), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .inst_code(inst_code), .alu_zero(alu_zero),
    .mem(mem_if0), .ir_write(d0_ir_write), .pc_write(d0_pc_write), .pc_sel(d0_pc_sel),
    .alu_src_b(d0_alu_src_b), .alu_op(d0_alu_op), .reg_write(d0_reg_write),
    .wb_sel(d0_wb_sel), .trap(d0_trap), .retired(d0_retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle's sampling point (inputs may be changed after).
  task automatic nxt();
    @(negedge clk);
  endtask

  // Called at the start of a FETCH cycle: complete fetch, land in DECODE.
  task automatic do_fetch(input logic [31:0] instr);
    mem_if.mem_ready = 1'b1;
    inst_code = instr;
    #1;
    chk("fetch_req",   32'(mem_if.mem_req),      32'd1);
    chk("fetch_asel",  32'(mem_if.mem_addr_sel), 32'd0);
    chk("fetch_irw",   32'(ir_write),            32'd1);
    chk("fetch_pcw",   32'(pc_write),            32'd1);
    chk("fetch_pcsel", 32'(pc_sel),              32'd0);
    nxt();
    mem_if.mem_ready = 1'b0;
    #1;
    chk("dec_req",  32'(mem_if.mem_req), 32'd0);
    chk("dec_regw", 32'(reg_write),      32'd0);
  endtask

  initial begin
    reset = 1'b1; inst_code = '0; alu_zero = 1'b0;
    mem_if.mem_ready = 1'b0; mem_if0.mem_ready = 1'b0;
    nxt(); #1;
    chk("rst_req",     32'(mem_if.mem_req), 32'd0);
    chk("rst_trap",    32'(trap),           32'd0);
    chk("rst_retired", retired,             32'd0);
    nxt();
    reset = 1'b0; #1;
    chk("post_rst_req", 32'(mem_if.mem_req), 32'd1);
    chk("post_rst_irw", 32'(ir_write),       32'd0);

    // ADDI x1,x0,5
    do_fetch(I_ADDI);
    nxt(); #1;
    chk("addi_srcb",  32'(alu_src_b), 32'd1);
    chk("addi_aluop", 32'(alu_op),    32'd2);
    chk("addi_regw0", 32'(reg_write), 32'd0);
    nxt(); #1;
    chk("addi_regw",  32'(reg_write), 32'd1);
    chk("addi_wbsel", 32'(wb_sel),    32'd0);
    nxt(); #1;
    chk("addi_regw_off", 32'(reg_write),       32'd0);
    chk("addi_back_req", 32'(mem_if.mem_req),  32'd1);
    chk("addi_retired",  retired,              32'd1);

    // LW with three wait cycles in MEM
    do_fetch(I_LW);
    nxt(); #1;
    chk("lw_srcb",  32'(alu_src_b), 32'd1);
    chk("lw_aluop", 32'(alu_op),    32'd0);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("lw_wait_req",  32'(mem_if.mem_req),      32'd1);
      chk("lw_wait_asel", 32'(mem_if.mem_addr_sel), 32'd1);
      chk("lw_wait_we",   32'(mem_if.mem_we),       32'd0);
    end
    nxt();
    mem_if.mem_ready = 1'b1; #1;
    chk("lw_ready_req", 32'(mem_if.mem_req), 32'd1);
    nxt();
    mem_if.mem_ready = 1'b0; #1;
    chk("lw_wb_regw",  32'(reg_write),       32'd1);
    chk("lw_wb_sel",   32'(wb_sel),          32'd1);
    chk("lw_wb_req",   32'(mem_if.mem_req),  32'd0);
    nxt(); #1;
    chk("lw_retired",  retired,              32'd2);

    // SW, zero-wait
    do_fetch(I_SW);
    nxt(); #1;
    chk("sw_srcb", 32'(alu_src_b), 32'd1);
    nxt();
    mem_if.mem_ready = 1'b1; #1;
    chk("sw_we",   32'(mem_if.mem_we),       32'd1);
    chk("sw_asel", 32'(mem_if.mem_addr_sel), 32'd1);
    chk("sw_regw", 32'(reg_write),           32'd0);
    nxt();
    mem_if.mem_ready = 1'b0; #1;
    chk("sw_retired", retired,             32'd3);
    chk("sw_back_we", 32'(mem_if.mem_we),  32'd0);

    // BEQ taken
    do_fetch(I_BEQ);
    nxt();
    alu_zero = 1'b1; #1;
    chk("beq_t_pcw",   32'(pc_write),  32'd1);
    chk("beq_t_pcsel", 32'(pc_sel),    32'd1);
    chk("beq_t_aluop", 32'(alu_op),    32'd1);
    chk("beq_t_srcb",  32'(alu_src_b), 32'd0);
    nxt(); alu_zero = 1'b0; #1;
    chk("beq_t_retired", retired, 32'd4);

    // BEQ not taken
    do_fetch(I_BEQ);
    nxt();
    alu_zero = 1'b0; #1;
    chk("beq_nt_pcw", 32'(pc_write), 32'd0);
    nxt(); #1;
    chk("beq_nt_retired", retired, 32'd5);

    // BNE taken (zero clear)
    do_fetch(I_BNE);
    nxt();
    alu_zero = 1'b0; #1;
    chk("bne_t_pcw", 32'(pc_write), 32'd1);
    nxt(); #1;
    chk("bne_t_retired", retired, 32'd6);

    // LUI
    do_fetch(I_LUI);
    nxt(); nxt(); #1;
    chk("lui_regw",  32'(reg_write), 32'd1);
    chk("lui_wbsel", 32'(wb_sel),    32'd2);
    nxt(); #1;
    chk("lui_retired", retired, 32'd7);

    // R-type ADD
    do_fetch(I_ADD);
    nxt(); #1;
    chk("add_srcb",  32'(alu_src_b), 32'd0);
    chk("add_aluop", 32'(alu_op),    32'd2);
    nxt(); #1;
    chk("add_wbsel", 32'(wb_sel), 32'd0);
    nxt(); #1;
    chk("add_retired", retired, 32'd8);

    // Illegal opcode -> TRAP, then terminal
    do_fetch(I_BAD);
    nxt(); #1;
    chk("ill_trap", 32'(trap),            32'd1);
    chk("ill_req",  32'(mem_if.mem_req),  32'd0);
    mem_if.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt(); #1;
      chk("ill_hold_req",  32'(mem_if.mem_req), 32'd0);
      chk("ill_hold_irw",  32'(ir_write),       32'd0);
    end
    chk("ill_retired", retired, 32'd8);
    mem_if.mem_ready = 1'b0;

    // Reset exits TRAP
    reset = 1'b1; nxt(); reset = 1'b0; #1;
    chk("rst2_trap",    32'(trap),           32'd0);
    chk("rst2_retired", retired,             32'd0);
    chk("rst2_req",     32'(mem_if.mem_req), 32'd1);

    // Retire one, then reset in the middle of a store
    do_fetch(I_ADDI);
    nxt(); nxt(); nxt(); #1;
    chk("pre_rst_retired", retired, 32'd1);
    do_fetch(I_SW);
    nxt(); nxt(); #1;
    chk("midst_we",  32'(mem_if.mem_we),  32'd1);
    chk("midst_req", 32'(mem_if.mem_req), 32'd1);
    #2 reset = 1'b1; #1;
    chk("midst_rst_req",     32'(mem_if.mem_req), 32'd0);
    chk("midst_rst_we",      32'(mem_if.mem_we),  32'd0);
    chk("midst_rst_retired", retired,             32'd0);
    nxt(); reset = 1'b0; #1;
    chk("midst_fetch_req",  32'(mem_if.mem_req),      32'd1);
    chk("midst_fetch_asel", 32'(mem_if.mem_addr_sel), 32'd0);

    // Branch with illegal funct3 -> TRAP without PC write
    do_fetch(I_BBAD);
    nxt(); alu_zero = 1'b1; #1;
    chk("bbad_pcw", 32'(pc_write), 32'd0);
    nxt(); alu_zero = 1'b0; #1;
    chk("bbad_trap",    32'(trap), 32'd1);
    chk("bbad_retired", retired,   32'd0);

    // Fetch timeout: 16 waiting cycles then TRAP
    reset = 1'b1; nxt(); reset = 1'b0; #1;
    for (int i = 1; i < 16; i++) begin
      nxt(); #1;
    end
    chk("to_c16_req",  32'(mem_if.mem_req), 32'd1);
    chk("to_c16_trap", 32'(trap),           32'd0);
    nxt(); #1;
    chk("to_trap", 32'(trap),           32'd1);
    chk("to_req",  32'(mem_if.mem_req), 32'd0);

    // MEM_TIMEOUT=0 instance has been waiting in FETCH throughout
    for (int i = 0; i < 30; i++) nxt();
    #1;
    chk("nto_req",  32'(mem_if0.mem_req), 32'd1);
    chk("nto_trap", 32'(d0_trap),         32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
